combo_lock_core: RTL and testbench

- Parametrised keypad combination-lock engine. It replaces the fixed 6-digit lock FSM, digit FSM and sampler group.
- Accepts synchronized keypad strobes, sets the password, checks attempts and counts failures.
- Enforces a timed lockout after repeated failures.
- Drives status and entry-buffer outputs for the existing seven-segment and LED logic in the top level.

---
 rtl/combo_lock_core.sv | 217 +++++++++++++++++++++
 tb/tb_combo_lock_core.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_core.sv
// Keypad combination-lock engine: key accept/debounce, password set/verify, failure count and timed lockout.
// Optional MASTER_CODE_EN: a full entry equal to MASTER_CODE unlocks from ATTEMPT and ends a lockout early.
module combo_lock_core #(
    parameter int NUM_DIGITS     = 6,
    parameter int ACCEPT_DLY     = 2,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 50000000,
    parameter logic [4*NUM_DIGITS-1:0] MASTER_CODE = '0,
    localparam int EW = 4*NUM_DIGITS,
    localparam int DW = $clog2(NUM_DIGITS+1),
    localparam int FW = $clog2(MAX_FAILS+1),
    localparam int LW = $clog2(LOCKOUT_CYCLES+1)
) (
    input  logic          MAX10_CLK1_50,
    input  logic          reset,
    input  logic          key_valid,
    input  logic [3:0]    key_code,
    output logic [2:0]    state,
    output logic          is_open,
    output logic [EW-1:0] entry,
    output logic [DW-1:0] digit_cnt,
    output logic [FW-1:0] fail_cnt,
    output logic [LW-1:0] lockout_left,
    output logic          key_stb,
    output logic          unlock_pulse,
    output logic          fail_pulse
);
    // state    | meaning
    // OPEN     | unlocked, first digit starts a new password
    // SET      | collecting a new password, enter commits a full entry
    // LOCKED   | password stored, first digit starts an attempt
    // ATTEMPT  | collecting an attempt, enter compares
    // LOCKOUT  | too many failures, keys ignored until the timer expires

    localparam int AW = $clog2(ACCEPT_DLY+1);
    localparam logic [EW-1:0] ENTRY_CLR = {NUM_DIGITS{4'hF}};
`ifdef MASTER_CODE_EN
    localparam bit MASTER_EN = 1'b1;
`else
    localparam bit MASTER_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_OPEN    = 3'd0,
        ST_SET     = 3'd1,
        ST_LOCKED  = 3'd2,
        ST_ATTEMPT = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   acc_cnt;
    logic [3:0]      key_q;
    logic [EW-1:0]   password;
    logic            is_digit;
    logic            is_enter;
    logic            entry_full;
    logic            pw_hit;
    logic            master_hit;

    assign state      = state_q;
    assign is_digit   = (key_q < 4'hE);
    assign is_enter   = (key_q == 4'hE);
    assign entry_full = (digit_cnt == DW'(NUM_DIGITS));
    assign pw_hit     = entry_full && (entry == password);
    assign master_hit = MASTER_EN && entry_full && (entry == MASTER_CODE);

    function automatic logic [EW-1:0] put_digit(input logic [EW-1:0] cur,
                                                input logic [DW-1:0] idx,
                                                input logic [3:0]    d);
        logic [EW-1:0] r;
        r = cur;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == DW'(i)) r[4*(NUM_DIGITS-1-i) +: 4] = d;
        end
        return r;
    endfunction

    // Counter saturates at ACCEPT_DLY, so a held key strobes exactly once.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            acc_cnt <= '0;
            key_q   <= 4'h0;
            key_stb <= 1'b0;
        end else begin
            key_stb <= 1'b0;
            if (!key_valid) begin
                acc_cnt <= '0;
            end else if (acc_cnt != AW'(ACCEPT_DLY)) begin
                acc_cnt <= acc_cnt + AW'(1);
                if (acc_cnt == AW'(ACCEPT_DLY-1)) begin
                    key_stb <= 1'b1;
                    key_q   <= key_code;
                end
            end
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            state_q      <= ST_OPEN;
            is_open      <= 1'b1;
            entry        <= ENTRY_CLR;
            digit_cnt    <= '0;
            fail_cnt     <= '0;
            lockout_left <= '0;
            password     <= '0;
            unlock_pulse <= 1'b0;
            fail_pulse   <= 1'b0;
        end else begin
            unlock_pulse <= 1'b0;
            fail_pulse   <= 1'b0;
            case (state_q)
                ST_OPEN: begin
                    if (key_stb && is_digit) begin
                        state_q   <= ST_SET;
                        is_open   <= 1'b0;
                        entry     <= put_digit(ENTRY_CLR, '0, key_q);
                        digit_cnt <= DW'(1);
                    end
                end
                ST_SET: begin
                    if (key_stb) begin
                        if (is_digit) begin
                            if (!entry_full) begin
                                entry     <= put_digit(entry, digit_cnt, key_q);
                                digit_cnt <= digit_cnt + DW'(1);
                            end
                        end else begin
                            if (is_enter && entry_full) begin
                                password <= entry;
                                state_q  <= ST_LOCKED;
                            end
                            entry     <= ENTRY_CLR;
                            digit_cnt <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (key_stb && is_digit) begin
                        state_q   <= ST_ATTEMPT;
                        entry     <= put_digit(ENTRY_CLR, '0, key_q);
                        digit_cnt <= DW'(1);
                    end
                end
                ST_ATTEMPT: begin
                    if (key_stb) begin
                        if (is_digit) begin
                            if (!entry_full) begin
                                entry     <= put_digit(entry, digit_cnt, key_q);
                                digit_cnt <= digit_cnt + DW'(1);
                            end
                        end else if (!is_enter) begin
                            state_q   <= ST_LOCKED;
                            entry     <= ENTRY_CLR;
                            digit_cnt <= '0;
                        end else begin
                            entry     <= ENTRY_CLR;
                            digit_cnt <= '0;
                            if (pw_hit || master_hit) begin
                                state_q      <= ST_OPEN;
                                is_open      <= 1'b1;
                                unlock_pulse <= 1'b1;
                                fail_cnt     <= '0;
                            end else begin
                                fail_pulse <= 1'b1;
                                if (fail_cnt == FW'(MAX_FAILS-1)) begin
                                    state_q      <= ST_LOCKOUT;
                                    fail_cnt     <= FW'(MAX_FAILS);
                                    lockout_left <= LW'(LOCKOUT_CYCLES);
                                end else begin
                                    state_q  <= ST_LOCKED;
                                    fail_cnt <= fail_cnt + FW'(1);
                                end
                            end
                        end
                    end
                end
                ST_LOCKOUT: begin
                    lockout_left <= lockout_left - LW'(1);
                    if (lockout_left == LW'(1)) begin
                        state_q   <= ST_LOCKED;
                        fail_cnt  <= '0;
                        entry     <= ENTRY_CLR;
                        digit_cnt <= '0;
                    end
`ifdef MASTER_CODE_EN
                    // Master code wins over a timer expiry landing on the same cycle.
                    if (key_stb) begin
                        if (is_digit) begin
                            if (!entry_full) begin
                                entry     <= put_digit(entry, digit_cnt, key_q);
                                digit_cnt <= digit_cnt + DW'(1);
                            end
                        end else begin
                            entry     <= ENTRY_CLR;
                            digit_cnt <= '0;
                            if (is_enter && master_hit) begin
                                state_q      <= ST_OPEN;
                                is_open      <= 1'b1;
                                unlock_pulse <= 1'b1;
                                fail_cnt     <= '0;
                                lockout_left <= '0;
                            end
                        end
                    end
`endif
                end
                default: begin
                    state_q <= ST_OPEN;
                    is_open <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_combo_lock_core.sv
// Directed bench for combo_lock_core (4 digits, accept delay 2, 3 fails, 20-cycle lockout).
module tb_combo_lock_core;
    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [2:0]  state;
    logic        is_open;
    logic [15:0] entry;
    logic [2:0]  digit_cnt;
    logic [1:0]  fail_cnt;
    logic [4:0]  lockout_left;
    logic        key_stb;
    logic        unlock_pulse;
    logic        fail_pulse;

    int checks = 0;
    int failures = 0;
    int stb_cnt = 0;
    int unlock_cnt = 0;
    int fail_cnt_pulses = 0;

    localparam logic [2:0] S_OPEN = 3'd0, S_SET = 3'd1, S_LOCKED = 3'd2, S_ATT = 3'd3, S_LOCKOUT = 3'd4;

    combo_lock_core #(
        .NUM_DIGITS(4), .ACCEPT_DLY(2), .MAX_FAILS(3), .LOCKOUT_CYCLES(20)
    ) dut (
        .MAX10_CLK1_50(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .state(state), .is_open(is_open), .entry(entry), .digit_cnt(digit_cnt),
        .fail_cnt(fail_cnt), .lockout_left(lockout_left), .key_stb(key_stb),
        .unlock_pulse(unlock_pulse), .fail_pulse(fail_pulse)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (key_stb) stb_cnt++;
        if (unlock_pulse) unlock_cnt++;
        if (fail_pulse) fail_cnt_pulses++;
    end

    typedef struct {
        logic [3:0]  code;
        logic [2:0]  st;
        logic [15:0] ent;
        logic [2:0]  dc;
        logic [1:0]  fc;
    } vec_t;

    vec_t vecs[33];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_code  = code;
        key_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press_seq(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                             input logic [3:0] d, input logic [3:0] e);
        press(a); press(b); press(c); press(d); press(e);
    endtask

    initial begin
        int stb_base;
        bit seen;

        vecs[0]  = '{4'h1, S_SET,    16'h1FFF, 3'd1, 2'd0};
        vecs[1]  = '{4'h2, S_SET,    16'h12FF, 3'd2, 2'd0};
        vecs[2]  = '{4'hE, S_SET,    16'hFFFF, 3'd0, 2'd0};
        vecs[3]  = '{4'h1, S_SET,    16'h1FFF, 3'd1, 2'd0};
        vecs[4]  = '{4'h2, S_SET,    16'h12FF, 3'd2, 2'd0};
        vecs[5]  = '{4'h3, S_SET,    16'h123F, 3'd3, 2'd0};
        vecs[6]  = '{4'h4, S_SET,    16'h1234, 3'd4, 2'd0};
        vecs[7]  = '{4'h5, S_SET,    16'h1234, 3'd4, 2'd0};
        vecs[8]  = '{4'hE, S_LOCKED, 16'hFFFF, 3'd0, 2'd0};
        vecs[9]  = '{4'hE, S_LOCKED, 16'hFFFF, 3'd0, 2'd0};
        vecs[10] = '{4'hF, S_LOCKED, 16'hFFFF, 3'd0, 2'd0};
        vecs[11] = '{4'h7, S_ATT,    16'h7FFF, 3'd1, 2'd0};
        vecs[12] = '{4'hF, S_LOCKED, 16'hFFFF, 3'd0, 2'd0};
        vecs[13] = '{4'h9, S_ATT,    16'h9FFF, 3'd1, 2'd0};
        vecs[14] = '{4'h9, S_ATT,    16'h99FF, 3'd2, 2'd0};
        vecs[15] = '{4'h9, S_ATT,    16'h999F, 3'd3, 2'd0};
        vecs[16] = '{4'h9, S_ATT,    16'h9999, 3'd4, 2'd0};
        vecs[17] = '{4'hE, S_LOCKED, 16'hFFFF, 3'd0, 2'd1};
        vecs[18] = '{4'h1, S_ATT,    16'h1FFF, 3'd1, 2'd1};
        vecs[19] = '{4'h2, S_ATT,    16'h12FF, 3'd2, 2'd1};
        vecs[20] = '{4'h3, S_ATT,    16'h123F, 3'd3, 2'd1};
        vecs[21] = '{4'h4, S_ATT,    16'h1234, 3'd4, 2'd1};
        vecs[22] = '{4'hE, S_OPEN,   16'hFFFF, 3'd0, 2'd0};
        vecs[23] = '{4'hE, S_OPEN,   16'hFFFF, 3'd0, 2'd0};
        vecs[24] = '{4'hF, S_OPEN,   16'hFFFF, 3'd0, 2'd0};
        vecs[25] = '{4'h1, S_SET,    16'h1FFF, 3'd1, 2'd0};
        vecs[26] = '{4'h2, S_SET,    16'h12FF, 3'd2, 2'd0};
        vecs[27] = '{4'h3, S_SET,    16'h123F, 3'd3, 2'd0};
        vecs[28] = '{4'h4, S_SET,    16'h1234, 3'd4, 2'd0};
        vecs[29] = '{4'hE, S_LOCKED, 16'hFFFF, 3'd0, 2'd0};
        vecs[30] = '{4'h1, S_ATT,    16'h1FFF, 3'd1, 2'd0};
        vecs[31] = '{4'h2, S_ATT,    16'h12FF, 3'd2, 2'd0};
        vecs[32] = '{4'hE, S_LOCKED, 16'hFFFF, 3'd0, 2'd1};

        reset = 1'b1;
        key_valid = 1'b0;
        key_code = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_state", state, S_OPEN);
        check("rst_is_open", is_open, 1);
        check("rst_entry", entry, 16'hFFFF);
        check("rst_digit_cnt", digit_cnt, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_lockout_left", lockout_left, 0);
        check("rst_pulses", {key_stb, unlock_pulse, fail_pulse}, 0);
        reset = 1'b0;

        for (int i = 0; i < 33; i++) begin
            press(vecs[i].code);
            check($sformatf("v%0d_state", i), state, vecs[i].st);
            check($sformatf("v%0d_is_open", i), is_open, (vecs[i].st == S_OPEN));
            check($sformatf("v%0d_entry", i), entry, vecs[i].ent);
            check($sformatf("v%0d_digit_cnt", i), digit_cnt, vecs[i].dc);
            check($sformatf("v%0d_fail_cnt", i), fail_cnt, vecs[i].fc);
            check($sformatf("v%0d_lockout_left", i), lockout_left, 0);
        end
        check("table_stb_count", stb_cnt, 33);
        check("table_unlock_count", unlock_cnt, 1);
        check("table_fail_count", fail_cnt_pulses, 2);

        // Second failure, then third failure into lockout.
        press_seq(4'h9, 4'h9, 4'h9, 4'h9, 4'hE);
        check("fail2_state", state, S_LOCKED);
        check("fail2_fail_cnt", fail_cnt, 2);
        press(4'h9); press(4'h9); press(4'h9); press(4'h9);
        @(negedge clk);
        key_code = 4'hE;
        key_valid = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (state == S_LOCKOUT) seen = 1'b1;
        end
        check("lockout_entered", state, S_LOCKOUT);
        check("lockout_left_start", lockout_left, 20);
        check("lockout_fail_cnt", fail_cnt, 3);
        stb_base = stb_cnt;
        for (int i = 0; i < 20; i++) begin
            key_code  = 4'h1;
            key_valid = (i % 4 != 0) && (i < 16);
            @(negedge clk);
            check($sformatf("lo%0d_state", i), state, (i == 19) ? S_LOCKED : S_LOCKOUT);
            check($sformatf("lo%0d_left", i), lockout_left, 19 - i);
        end
        key_valid = 1'b0;
        check("lockout_stb_count", stb_cnt - stb_base, 4);
        check("lockout_end_fail_cnt", fail_cnt, 0);
        check("lockout_end_entry", entry, 16'hFFFF);
        check("lockout_end_digit_cnt", digit_cnt, 0);
        check("lockout_fail_pulses", fail_cnt_pulses, 4);

        // Long hold accepts once; a one-cycle glitch accepts nothing.
        repeat (2) @(negedge clk);
        stb_base = stb_cnt;
        key_code = 4'h5;
        key_valid = 1'b1;
        repeat (100) @(negedge clk);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_stb_count", stb_cnt - stb_base, 1);
        check("hold_entry", entry, 16'h5FFF);
        check("hold_state", state, S_ATT);
        stb_base = stb_cnt;
        key_code = 4'h6;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_stb_count", stb_cnt - stb_base, 0);
        check("glitch_entry", entry, 16'h5FFF);

        // Reset in the middle of an attempt.
        press(4'hF);
        press(4'h9);
        press(4'hE);
        press(4'h1);
        press(4'h2);
        check("pre_rst_state", state, S_ATT);
        check("pre_rst_digit_cnt", digit_cnt, 2);
        check("pre_rst_fail_cnt", fail_cnt, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_state", state, S_OPEN);
        check("mid_rst_entry", entry, 16'hFFFF);
        check("mid_rst_fail_cnt", fail_cnt, 0);
        check("mid_rst_digit_cnt", digit_cnt, 0);
        check("mid_rst_is_open", is_open, 1);
        reset = 1'b0;
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        check("post_rst_state", state, S_SET);
        check("post_rst_entry", entry, 16'h1234);
        press(4'hE);
        check("post_rst_commit", state, S_LOCKED);
        press_seq(4'h1, 4'h2, 4'h3, 4'h4, 4'hE);
        check("post_rst_unlock_state", state, S_OPEN);
        check("post_rst_unlock_count", unlock_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
